serial_tx_engine: RTL and testbench

Parametrised successor to the team's single-shot serial transmitter: shifts variable-length words onto sda_o/scl_o using a 4-phase bit cell (setup, rise, high, fall).
- Adds a valid/ready handshake with a one-word holding register, so back-to-back frames run with no idle gap.
- Adds per-word frame length and per-word MSB/LSB-first order, configurable clock polarity, and a done pulse.
- Sits between a host-side word source and the serial pins; fully synchronous to clk_i, with no derived clock.

---
 rtl/serial_tx_pkg.sv | 22 ++
 rtl/prescaler_tick.sv | 28 ++
 rtl/serial_tx_engine.sv | 165 ++++++++++++++++
 tb/tb_serial_tx_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmit engine and its companions.
package serial_tx_pkg;

  // One-hot bit-cell phase encoding.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SETUP = 5'b00010,
    ST_RISE  = 5'b00100,
    ST_HIGH  = 5'b01000,
    ST_FALL  = 5'b10000
  } tx_state_e;

  // Number of phases in one bit cell.
  localparam int unsigned PHASE_COUNT = 4;

  // A length of zero, or one wider than the data path, means a full-width word.
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned width);
    if (len == 0 || len > width) return width;
    return len;
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Countdown prescaler: emits a one-cycle tick every prescl+1 cycles.
module prescaler_tick #(
  parameter int unsigned PRSCL_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   reload,
  input  logic [PRSCL_WIDTH-1:0] prescl,
  output logic                   tick
);

  logic [PRSCL_WIDTH-1:0] count_q, count_d;

  assign tick = (count_q == '0);

  // Reload on request or on tick, otherwise count down.
  always_comb begin
    count_d = count_q - PRSCL_WIDTH'(1);
    if (reload || tick) count_d = prescl;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/serial_tx_engine.sv
// Serial word transmitter with 4-phase bit cells, a one-word holding
// register and per-word length and bit order.
module serial_tx_engine
  import serial_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRSCL_WIDTH = 8,
  parameter int unsigned LEN_WIDTH   = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [PRSCL_WIDTH-1:0] prescl_i,
  input  logic                   cpol_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  input  logic                   lsb_first_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   busy_o,
  output logic                   en_o,
  output logic                   sda_o,
  output logic                   scl_o,
  output logic                   done_o
);

  localparam logic [LEN_WIDTH-1:0] DW_L = LEN_WIDTH'(DATA_WIDTH);

  tx_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [LEN_WIDTH-1:0]   bits_left_q, bits_left_d;
  logic                   lsb_q, lsb_d;
  logic [PRSCL_WIDTH-1:0] prescl_q, prescl_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [LEN_WIDTH-1:0]   hold_len_q, hold_len_d;
  logic                   hold_lsb_q, hold_lsb_d;

  logic                   tick;
  logic                   accept;
  logic                   frame_end;
  logic                   load;
  logic [DATA_WIDTH-1:0]  ld_data;
  logic [LEN_WIDTH-1:0]   ld_len;
  logic                   ld_lsb;
  logic [LEN_WIDTH-1:0]   len_n;

  assign len_n     = LEN_WIDTH'(norm_len(32'(len_i), DATA_WIDTH));
  assign accept    = valid_i && !hold_valid_q;
  assign frame_end = (state_q == ST_FALL) && tick && (bits_left_q == LEN_WIDTH'(1));

  prescaler_tick #(
    .PRSCL_WIDTH(PRSCL_WIDTH)
  ) u_prescaler (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .reload  (load),
    .prescl  (load ? prescl_i : prescl_q),
    .tick    (tick)
  );

  // Phase sequencing, word loading and hold-register management.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bits_left_d  = bits_left_q;
    lsb_d        = lsb_q;
    prescl_d     = prescl_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_len_d   = hold_len_q;
    hold_lsb_d   = hold_lsb_q;
    load         = 1'b0;
    ld_data      = data_i;
    ld_len       = len_n;
    ld_lsb       = lsb_first_i;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: if (tick) state_d = ST_RISE;
      ST_RISE:  if (tick) state_d = ST_HIGH;
      ST_HIGH:  if (tick) state_d = ST_FALL;
      ST_FALL: begin
        if (tick) begin
          if (bits_left_q > LEN_WIDTH'(1)) begin
            shift_d     = lsb_q ? (shift_q >> 1) : (shift_q << 1);
            bits_left_d = bits_left_q - LEN_WIDTH'(1);
            state_d     = ST_SETUP;
          end else if (hold_valid_q) begin
            load         = 1'b1;
            ld_data      = hold_data_q;
            ld_len       = hold_len_q;
            ld_lsb       = hold_lsb_q;
            hold_valid_d = 1'b0;
            state_d      = ST_SETUP;
          end else if (valid_i) begin
            load    = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Mid-frame accept parks the word; the frame-end case is a bypass load above.
    if (accept && (state_q != ST_IDLE) && !frame_end) begin
      hold_valid_d = 1'b1;
      hold_data_d  = data_i;
      hold_len_d   = len_n;
      hold_lsb_d   = lsb_first_i;
    end

    // MSB-first words are left-aligned so the active bit is always the top bit.
    if (load) begin
      shift_d     = ld_lsb ? ld_data : (ld_data << (DW_L - ld_len));
      bits_left_d = ld_len;
      lsb_d       = ld_lsb;
      prescl_d    = prescl_i;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bits_left_q  <= '0;
      lsb_q        <= 1'b0;
      prescl_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_len_q   <= '0;
      hold_lsb_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bits_left_q  <= bits_left_d;
      lsb_q        <= lsb_d;
      prescl_q     <= prescl_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_len_q   <= hold_len_d;
      hold_lsb_q   <= hold_lsb_d;
    end
  end

  // Pin outputs decoded from the registered phase.
  always_comb begin
    en_o    = (state_q != ST_IDLE);
    sda_o   = 1'b0;
    scl_o   = cpol_i;
    if (en_o) sda_o = lsb_q ? shift_q[0] : shift_q[DATA_WIDTH-1];
    if (state_q == ST_RISE || state_q == ST_HIGH) scl_o = ~cpol_i;
    done_o  = frame_end;
    ready_o = ~hold_valid_q;
    busy_o  = en_o | hold_valid_q;
  end

endmodule

// File: tb/tb_serial_tx_engine.sv
// Directed bench for serial_tx_engine (DATA_WIDTH=8).
module tb_serial_tx_engine;
  import serial_tx_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] prescl_i;
  logic       cpol_i;
  logic [7:0] data_i;
  logic [3:0] len_i;
  logic       lsb_first_i;
  logic       valid_i;
  logic       ready_o, busy_o, en_o, sda_o, scl_o, done_o;

  int checks   = 0;
  int failures = 0;

  serial_tx_engine #(
    .DATA_WIDTH(8),
    .PRSCL_WIDTH(8),
    .LEN_WIDTH(4)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .prescl_i    (prescl_i),
    .cpol_i      (cpol_i),
    .data_i      (data_i),
    .len_i       (len_i),
    .lsb_first_i (lsb_first_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .en_o        (en_o),
    .sda_o       (sda_o),
    .scl_o       (scl_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Offer one word from idle; returns at the negedge after the accept edge.
  task automatic start_word(input logic [7:0] d, input logic [3:0] l, input logic lsb);
    data_i      = d;
    len_i       = l;
    lsb_first_i = lsb;
    valid_i     = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    checks++; if (en_o !== 1'b0)    begin failures++; $display("FAIL reset_en got=%b exp=0", en_o); end
    checks++; if (sda_o !== 1'b0)   begin failures++; $display("FAIL reset_sda got=%b exp=0", sda_o); end
    checks++; if (scl_o !== 1'b0)   begin failures++; $display("FAIL reset_scl got=%b exp=0", scl_o); end
    checks++; if (done_o !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (busy_o !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_msb_a5();
    logic [7:0] bits;
    int ph;
    bits = 8'b1010_0101;  // expected sda order, first bit at index 7
    prescl_i = 8'd0;
    start_word(8'hA5, 4'd0, 1'b0);
    for (int n = 0; n < 32; n++) begin
      ph = n % 4;
      checks++; if (en_o !== 1'b1) begin failures++; $display("FAIL msb_en n=%0d got=%b exp=1", n, en_o); end
      checks++; if (sda_o !== bits[7 - n/4]) begin failures++; $display("FAIL msb_sda n=%0d got=%b exp=%b", n, sda_o, bits[7 - n/4]); end
      checks++; if (scl_o !== (ph == 1 || ph == 2)) begin failures++; $display("FAIL msb_scl n=%0d got=%b exp=%b", n, scl_o, (ph == 1 || ph == 2)); end
      checks++; if (done_o !== (n == 31)) begin failures++; $display("FAIL msb_done n=%0d got=%b exp=%b", n, done_o, (n == 31)); end
      @(negedge clk_i);
    end
    checks++; if (en_o !== 1'b0)   begin failures++; $display("FAIL msb_en_after got=%b exp=0", en_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL msb_done_after got=%b exp=0", done_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL msb_busy_after got=%b exp=0", busy_o); end
  endtask

  task automatic test_lsb_len3();
    logic [2:0] bits;
    int ph;
    bits = 3'b110;  // bit order 0,1,1 from index 0
    prescl_i = 8'd3;
    start_word(8'h06, 4'd3, 1'b1);
    prescl_i = 8'd0;  // must not affect the running frame
    for (int n = 0; n < 48; n++) begin
      ph = (n / 4) % 4;
      checks++; if (en_o !== 1'b1) begin failures++; $display("FAIL lsb_en n=%0d got=%b exp=1", n, en_o); end
      checks++; if (sda_o !== bits[n/16]) begin failures++; $display("FAIL lsb_sda n=%0d got=%b exp=%b", n, sda_o, bits[n/16]); end
      checks++; if (scl_o !== (ph == 1 || ph == 2)) begin failures++; $display("FAIL lsb_scl n=%0d got=%b exp=%b", n, scl_o, (ph == 1 || ph == 2)); end
      checks++; if (done_o !== (n == 47)) begin failures++; $display("FAIL lsb_done n=%0d got=%b exp=%b", n, done_o, (n == 47)); end
      @(negedge clk_i);
    end
    checks++; if (en_o !== 1'b0) begin failures++; $display("FAIL lsb_en_after got=%b exp=0", en_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    bits = 16'h817E;
    prescl_i = 8'd0;
    start_word(8'h81, 4'd0, 1'b0);
    for (int n = 0; n < 64; n++) begin
      checks++; if (en_o !== 1'b1) begin failures++; $display("FAIL b2b_en n=%0d got=%b exp=1", n, en_o); end
      checks++; if (sda_o !== bits[15 - n/4]) begin failures++; $display("FAIL b2b_sda n=%0d got=%b exp=%b", n, sda_o, bits[15 - n/4]); end
      checks++; if (done_o !== (n == 31 || n == 63)) begin failures++; $display("FAIL b2b_done n=%0d got=%b exp=%b", n, done_o, (n == 31 || n == 63)); end
      checks++; if (ready_o !== (n == 0 || n >= 32)) begin failures++; $display("FAIL b2b_ready n=%0d got=%b exp=%b", n, ready_o, (n == 0 || n >= 32)); end
      if (n == 0) begin data_i = 8'h7E; valid_i = 1'b1; end
      if (n == 1) valid_i = 1'b0;
      @(negedge clk_i);
    end
    checks++; if (en_o !== 1'b0)   begin failures++; $display("FAIL b2b_en_after got=%b exp=0", en_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_busy_after got=%b exp=0", busy_o); end
  endtask

  task automatic test_bypass_stall();
    logic [7:0] bits;
    logic exp_ready;
    bits = 8'b10_01_11_10;  // A, B, C, D, two bits each, first bit at index 7
    prescl_i = 8'd0;
    start_word(8'h02, 4'd2, 1'b0);
    for (int n = 0; n < 32; n++) begin
      exp_ready = !((n >= 9 && n <= 15) || (n >= 17 && n <= 23));
      checks++; if (en_o !== 1'b1) begin failures++; $display("FAIL byp_en n=%0d got=%b exp=1", n, en_o); end
      checks++; if (sda_o !== bits[7 - n/4]) begin failures++; $display("FAIL byp_sda n=%0d got=%b exp=%b", n, sda_o, bits[7 - n/4]); end
      checks++; if (done_o !== (n % 8 == 7)) begin failures++; $display("FAIL byp_done n=%0d got=%b exp=%b", n, done_o, (n % 8 == 7)); end
      checks++; if (ready_o !== exp_ready) begin failures++; $display("FAIL byp_ready n=%0d got=%b exp=%b", n, ready_o, exp_ready); end
      case (n)
        7:  begin data_i = 8'h01; len_i = 4'd2; lsb_first_i = 1'b0; valid_i = 1'b1; end
        8:  data_i = 8'h03;
        9:  begin data_i = 8'h01; lsb_first_i = 1'b1; end
        17: valid_i = 1'b0;
        default: ;
      endcase
      @(negedge clk_i);
    end
    checks++; if (en_o !== 1'b0)   begin failures++; $display("FAIL byp_en_after got=%b exp=0", en_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL byp_busy_after got=%b exp=0", busy_o); end
    lsb_first_i = 1'b0;
  endtask

  task automatic test_cpol1();
    cpol_i = 1'b1;
    @(negedge clk_i);
    checks++; if (scl_o !== 1'b1) begin failures++; $display("FAIL cpol_idle_scl got=%b exp=1", scl_o); end
    checks++; if (sda_o !== 1'b0) begin failures++; $display("FAIL cpol_idle_sda got=%b exp=0", sda_o); end
    checks++; if (en_o !== 1'b0)  begin failures++; $display("FAIL cpol_idle_en got=%b exp=0", en_o); end
    prescl_i = 8'd0;
    start_word(8'h01, 4'd1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++; if (scl_o !== (n == 0 || n == 3)) begin failures++; $display("FAIL cpol_scl n=%0d got=%b exp=%b", n, scl_o, (n == 0 || n == 3)); end
      checks++; if (sda_o !== 1'b1) begin failures++; $display("FAIL cpol_sda n=%0d got=%b exp=1", n, sda_o); end
      @(negedge clk_i);
    end
    checks++; if (scl_o !== 1'b1) begin failures++; $display("FAIL cpol_after_scl got=%b exp=1", scl_o); end
    checks++; if (en_o !== 1'b0)  begin failures++; $display("FAIL cpol_after_en got=%b exp=0", en_o); end
    cpol_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_midframe();
    logic seen;
    prescl_i = 8'd0;
    start_word(8'hFF, 4'd0, 1'b0);
    data_i  = 8'h55;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL rstmid_held got=%b exp=0", ready_o); end
    repeat (16) @(negedge clk_i);  // now inside bit 4
    checks++; if (done_o !== 1'b0 || en_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre en=%b done=%b exp en=1 done=0", en_o, done_o); end
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    checks++; if (en_o !== 1'b0)    begin failures++; $display("FAIL rstmid_en got=%b exp=0", en_o); end
    checks++; if (scl_o !== 1'b0)   begin failures++; $display("FAIL rstmid_scl got=%b exp=0", scl_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ready_o); end
    checks++; if (busy_o !== 1'b0)  begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0)  begin failures++; $display("FAIL rstmid_done got=%b exp=0", done_o); end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (en_o || done_o || sda_o) seen = 1'b1;
      @(negedge clk_i);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_held_sent got=%b exp=0", seen); end
  endtask

  initial begin
    reset_i     = 1'b0;
    prescl_i    = '0;
    cpol_i      = 1'b0;
    data_i      = '0;
    len_i       = '0;
    lsb_first_i = 1'b0;
    valid_i     = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_msb_a5();
    test_lsb_len3();
    test_back_to_back();
    test_bypass_stall();
    test_cpol1();
    test_reset_midframe();
    checks++; if (PHASE_COUNT != 4) begin failures++; $display("FAIL phase_count got=%0d exp=4", PHASE_COUNT); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
